// File: rtl/inst_rom_pipe.sv
// Pipelined instruction memory. It returns fetched words after LATENCY stall-aware register stages.
// A program-load write port fills the memory at run time. Reads are read-first on same-word collisions.
module inst_rom_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    input  logic              stall_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              rom_valid_o,
    output logic              rom_err_o,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i
);

    localparam int                AW          = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic [ADDR_W-1:0] fetch_widx;
    logic [ADDR_W-1:0] prog_widx;
    logic              fetch_bad;
    logic              prog_ok;
    logic [AW-1:0]     fetch_idx;
    logic [AW-1:0]     prog_idx;

    always_comb begin
        fetch_widx = {2'b00, rom_addr_i[ADDR_W-1:2]};
        prog_widx  = {2'b00, prog_addr_i[ADDR_W-1:2]};
        fetch_bad  = (rom_addr_i[1:0] != 2'b00) || (fetch_widx >= DEPTH_WORDS);
        prog_ok    = prog_we_i && (prog_addr_i[1:0] == 2'b00) && (prog_widx < DEPTH_WORDS);
        fetch_idx  = rom_addr_i[AW+1:2];
        prog_idx   = prog_addr_i[AW+1:2];
    end

    // Program load ignores reset and stall so boot logic can fill memory at any time.
    always_ff @(posedge clk) begin
        if (prog_ok) begin
            mem[prog_idx] <= prog_data_i;
        end
    end

    logic [DATA_W-1:0] data_reg [LATENCY];
    logic [LATENCY-1:0] valid_reg;
    logic [LATENCY-1:0] err_reg;

    // Stage 0 reads memory directly; the pre-write value is seen on a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            err_reg   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_reg[i] <= NOP_WORD;
            end
        end else if (!stall_i) begin
            valid_reg[0] <= rom_ce_i;
            err_reg[0]   <= rom_ce_i && fetch_bad;
            data_reg[0]  <= (rom_ce_i && !fetch_bad) ? mem[fetch_idx] : NOP_WORD;
            for (int i = 1; i < LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                err_reg[i]   <= err_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    assign rom_data_o  = data_reg[LATENCY-1];
    assign rom_valid_o = valid_reg[LATENCY-1];
    assign rom_err_o   = err_reg[LATENCY-1];

endmodule

// File: tb/tb_inst_rom_pipe.sv
// Drives four instances with LATENCY 1..4 and DEPTH 16 from shared stimulus.
// Checks each instance against a history-queue model of accepted fetches.
module tb_inst_rom_pipe;

    localparam int NINST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce_i = 1'b0;
    logic [31:0] rom_addr_i = '0;
    logic        stall_i = 1'b0;
    logic        prog_we_i = 1'b0;
    logic [31:0] prog_addr_i = '0;
    logic [31:0] prog_data_i = '0;

    logic [31:0]      dout_o  [NINST];
    logic [NINST-1:0] valid_o;
    logic [NINST-1:0] err_o;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        inst_rom_pipe #(
            .DATA_W(32), .ADDR_W(32), .DEPTH(16), .LATENCY(gi + 1), .NOP_WORD(32'h0000_0000)
        ) u_dut (
            .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
            .stall_i(stall_i), .rom_data_o(dout_o[gi]), .rom_valid_o(valid_o[gi]),
            .rom_err_o(err_o[gi]), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
            .prog_data_i(prog_data_i)
        );
    end

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        e;
    } ent_t;

    // Model: hist[k] is the stage-1 capture from k unstalled edges ago.
    ent_t        hist [$];
    logic [31:0] mem_m [16];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ce, input logic [31:0] a, input logic st,
                        input logic we, input logic [31:0] pa, input logic [31:0] pd);
        ent_t c;
        ent_t x;
        rst = r; rom_ce_i = ce; rom_addr_i = a; stall_i = st;
        prog_we_i = we; prog_addr_i = pa; prog_data_i = pd;
        @(posedge clk);
        #1;
        c.v = 1'b0; c.d = 32'h0; c.e = 1'b0;
        if (ce) begin
            c.v = 1'b1;
            if (a[1:0] != 2'b00 || (a >> 2) >= 32'd16) c.e = 1'b1;
            else c.d = mem_m[a[5:2]];
        end
        if (r) hist.delete();
        else if (!st) begin
            hist.push_front(c);
            if (hist.size() > NINST) void'(hist.pop_back());
        end
        if (we && pa[1:0] == 2'b00 && (pa >> 2) < 32'd16) mem_m[pa[5:2]] = pd;
        for (int l = 0; l < NINST; l++) begin
            x.v = 1'b0; x.d = 32'h0; x.e = 1'b0;
            if (hist.size() > l) x = hist[l];
            check($sformatf("lat%0d data", l + 1), dout_o[l], x.d);
            check($sformatf("lat%0d valid", l + 1), {31'b0, valid_o[l]}, {31'b0, x.v});
            check($sformatf("lat%0d err", l + 1), {31'b0, err_o[l]}, {31'b0, x.e});
        end
        $display("t=%0t rst=%b ce=%b addr=%h stall=%b we=%b paddr=%h pdata=%h | out1=%h/%b/%b out4=%h/%b/%b",
                 $time, r, ce, a, st, we, pa, pd, dout_o[0], valid_o[0], err_o[0],
                 dout_o[3], valid_o[3], err_o[3]);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            1:       return {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            2:       return {24'b0, 6'($urandom_range(16, 63)), 2'b00};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        @(negedge clk);

        // Reset with requests pending, then bubbles
        for (int i = 0; i < 3; i++) step(1, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 32'h0, 0, 0, 0, 0);
            check("bubble valid", {28'b0, valid_o}, 32'h0);
        end

        // Load words 0..3, fetch back-to-back
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1, 32'(i * 4), 32'h1111_0000 + 32'(i));
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i * 4), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0, 0);

        // Stall two cycles right after the 0x4 request
        step(0, 1, 32'h0, 0, 0, 0, 0);
        step(0, 1, 32'h4, 0, 0, 0, 0);
        step(0, 1, 32'h8, 1, 0, 0, 0);
        step(0, 1, 32'hC, 1, 0, 0, 0);
        step(0, 1, 32'h8, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0, 0);

        // Error fetches and ignored writes
        step(0, 0, 32'h0, 0, 1, 32'h3C, 32'hCAFE_F00D);
        step(0, 1, 32'h2, 0, 0, 0, 0);
        check("misaligned err", {31'b0, err_o[0]}, 32'h1);
        step(0, 1, 32'h40, 0, 1, 32'h40, 32'hDEAD_BEEF);
        check("range err", {31'b0, err_o[0]}, 32'h1);
        step(0, 1, 32'h3C, 0, 1, 32'h6, 32'h5555_5555);
        check("last word", dout_o[0], 32'hCAFE_F00D);
        for (int i = 0; i < 16; i++) step(0, 1, 32'(i * 4), 0, 0, 0, 0);

        // Read-first collision on word 5
        step(0, 0, 32'h0, 0, 1, 32'h14, 32'hAAAA_AAAA);
        step(0, 1, 32'h14, 0, 1, 32'h14, 32'hBBBB_BBBB);
        check("collision old", dout_o[0], 32'hAAAA_AAAA);
        step(0, 1, 32'h14, 0, 0, 0, 0);
        check("collision new", dout_o[0], 32'hBBBB_BBBB);

        // Reset with three fetches in flight
        step(0, 1, 32'h0, 0, 0, 0, 0);
        step(0, 1, 32'h4, 0, 0, 0, 0);
        step(0, 1, 32'h8, 0, 0, 0, 0);
        step(1, 1, 32'hC, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 0, 0, 0, 0);
            check("flush valid", {28'b0, valid_o}, 32'h0);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i * 4), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) < 2, ($urandom % 4) != 0, rand_addr(),
                 $urandom_range(0, 99) < 20, ($urandom % 3) == 0, rand_addr(), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
